// File: rtl/gpc_pkg.sv
// Shared helpers for packed key/value LUT buses.
// Both the table and the downstream LUT mux use these so the entry layout stays identical.
package gpc_pkg;

  function automatic int kdw(input int kw, input int dw);
    return kw + dw;
  endfunction

  // Low bit of entry i on a packed lut bus; the key sits in the upper kw bits of the slice.
  function automatic int lut_lo(input int i, input int kw, input int dw);
    return i * kdw(kw, dw);
  endfunction

endpackage

// File: rtl/kv_table_if.sv
// Write, lookup and result handshakes plus table status/bus for kv_table.
interface kv_table_if #(
  parameter int NR = 4,
  parameter int KW = 4,
  parameter int DW = 8
);
  localparam int CW = $clog2(NR + 1);

  logic                   wr_valid;
  logic                   wr_ready;
  logic [KW-1:0]          wr_key;
  logic [DW-1:0]          wr_val;
  logic                   clr;
  logic                   lk_valid;
  logic                   lk_ready;
  logic [KW-1:0]          lk_key;
  logic [DW-1:0]          def;
  logic                   rs_valid;
  logic                   rs_ready;
  logic                   rs_hit;
  logic [DW-1:0]          rs_val;
  logic [CW-1:0]          count;
  logic                   full;
  logic [NR*(KW+DW)-1:0]  lut;

  modport master (
    output wr_valid, wr_key, wr_val, clr, lk_valid, lk_key, def, rs_ready,
    input  wr_ready, lk_ready, rs_valid, rs_hit, rs_val, count, full, lut
  );

  modport slave (
    input  wr_valid, wr_key, wr_val, clr, lk_valid, lk_key, def, rs_ready,
    output wr_ready, lk_ready, rs_valid, rs_hit, rs_val, count, full, lut
  );
endinterface

// File: rtl/kv_match.sv
// Combinational key match across the used table entries.
module kv_match #(
  parameter int NR = 4,
  parameter int KW = 4,
  parameter int DW = 8
) (
  input  logic [KW-1:0]         key,
  input  logic [NR-1:0][KW-1:0] keys,
  input  logic [NR-1:0][DW-1:0] vals,
  input  logic [NR-1:0]         used,
  output logic [NR-1:0]         onehot,
  output logic                  hit,
  output logic [DW-1:0]         val
);

  // Keys are unique among used entries, so OR-reducing the matched values selects one.
  always_comb begin
    onehot = '0;
    val    = '0;
    for (int i = 0; i < NR; i++) begin
      if (used[i] && keys[i] == key) begin
        onehot[i] = 1'b1;
        val       = val | vals[i];
      end
    end
  end

  assign hit = |onehot;

endmodule

// File: rtl/kv_table.sv
// Run-time loadable key/value table driving a packed LUT bus,
// with a registered hit/miss lookup path.
module kv_table
  import gpc_pkg::*;
#(
  parameter int NR = 4,
  parameter int KW = 4,
  parameter int DW = 8
) (
  input  logic      clk,
  input  logic      rst,
  kv_table_if.slave bus
);

  localparam int CW  = $clog2(NR + 1);
  localparam int KDW = kdw(KW, DW);

  logic [NR-1:0][KW-1:0] keys;
  logic [NR-1:0][DW-1:0] vals;
  logic [CW-1:0]         cnt;
  logic [NR-1:0]         used;
  logic                  full;

  logic [NR-1:0] w_onehot;
  logic          w_hit;
  logic [DW-1:0] w_val;
  logic [NR-1:0] l_onehot;
  logic          l_hit;
  logic [DW-1:0] l_val;
  logic          unused_match;

  logic          rs_valid;
  logic          rs_hit;
  logic [DW-1:0] rs_val;
  logic          wr_ready;
  logic          lk_ready;
  logic [NR*KDW-1:0] lut_bus;

  always_comb begin
    used = '0;
    for (int i = 0; i < NR; i++) used[i] = (i < int'(cnt));
  end

  kv_match #(.NR(NR), .KW(KW), .DW(DW)) u_wr_match (
    .key(bus.wr_key), .keys(keys), .vals(vals), .used(used),
    .onehot(w_onehot), .hit(w_hit), .val(w_val)
  );

  kv_match #(.NR(NR), .KW(KW), .DW(DW)) u_lk_match (
    .key(bus.lk_key), .keys(keys), .vals(vals), .used(used),
    .onehot(l_onehot), .hit(l_hit), .val(l_val)
  );

  assign unused_match = ^{l_onehot, w_val};

  assign full     = (cnt == CW'(NR));
  assign wr_ready = !bus.clr && (!full || w_hit);
  assign lk_ready = !rs_valid || bus.rs_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys <= '0;
      vals <= '0;
      cnt  <= '0;
    end else if (bus.clr) begin
      keys <= '0;
      vals <= '0;
      cnt  <= '0;
    end else if (bus.wr_valid && wr_ready) begin
      if (w_hit) begin
        for (int i = 0; i < NR; i++)
          if (w_onehot[i]) vals[i] <= bus.wr_val;
      end else begin
        // Not full here (wr_ready), so slot cnt is a valid free entry.
        for (int i = 0; i < NR; i++) begin
          if (CW'(i) == cnt) begin
            keys[i] <= bus.wr_key;
            vals[i] <= bus.wr_val;
          end
        end
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Lookup sees pre-edge table contents; result fields hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_valid <= 1'b0;
      rs_hit   <= 1'b0;
      rs_val   <= '0;
    end else if (bus.lk_valid && lk_ready) begin
      rs_valid <= 1'b1;
      rs_hit   <= l_hit;
      rs_val   <= l_hit ? l_val : bus.def;
    end else if (bus.rs_ready) begin
      rs_valid <= 1'b0;
    end
  end

  // Unused slots mirror entry 0 so the mux only ever sees a real pair.
  always_comb begin
    lut_bus = '0;
    if (cnt != '0) begin
      for (int i = 0; i < NR; i++)
        lut_bus[lut_lo(i, KW, DW) +: KDW] = used[i] ? {keys[i], vals[i]} : {keys[0], vals[0]};
    end
  end

  assign bus.wr_ready = wr_ready;
  assign bus.lk_ready = lk_ready;
  assign bus.rs_valid = rs_valid;
  assign bus.rs_hit   = rs_hit;
  assign bus.rs_val   = rs_val;
  assign bus.count    = cnt;
  assign bus.full     = full;
  assign bus.lut      = lut_bus;

endmodule
